// File: rtl/cla_seq_nibble_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit CLA slice, one nibble per clock.
// Optional subtract/overflow support is enabled by defining CLA_SEQ_SUB_EN.

module cla_4bit_augment (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_sum,
    output logic       o_p,
    output logic       o_g
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_sum = w_p ^ w_c;
    assign o_p   = &w_p;
    assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_seq_nibble_adder #(
    parameter int WIDTH = 16,
    parameter int NIB   = WIDTH / 4,
    parameter int CW    = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             p_all,
    output logic             g_all
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_p_acc;
    logic             r_g_acc;
    logic             r_cout;
    logic             r_p_all;
    logic             r_g_all;
    logic             r_out_valid;
`ifdef CLA_SEQ_SUB_EN
    logic             r_sub;
    logic             r_ovf;
`endif

    logic [3:0] w_a_nibs [NIB];
    logic [3:0] w_b_nibs [NIB];
    logic [3:0] w_a_nib;
    logic [3:0] w_b_nib;
    logic [3:0] w_b_slice;
    logic [3:0] w_s_sum;
    logic       w_s_p;
    logic       w_s_g;
    logic       w_carry_nx;
    logic       w_p_nx;
    logic       w_g_nx;
    logic       w_last;
    logic       w_init_carry;

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign w_a_nibs[gi] = r_a[4*gi +: 4];
        assign w_b_nibs[gi] = r_b[4*gi +: 4];
    end

    assign w_a_nib = w_a_nibs[r_cnt];
    assign w_b_nib = w_b_nibs[r_cnt];

    // Operand B conditioning and initial carry selection (subtract inverts B, forces carry-in).
    always_comb begin
        w_b_slice    = w_b_nib;
        w_init_carry = cin;
`ifdef CLA_SEQ_SUB_EN
        if (r_sub) begin
            w_b_slice = ~w_b_nib;
        end else begin
            w_b_slice = w_b_nib;
        end
        if (sub) begin
            w_init_carry = 1'b1;
        end else begin
            w_init_carry = cin;
        end
`endif
    end

    cla_4bit_augment u_slice (
        .i_a   (w_a_nib),
        .i_b   (w_b_slice),
        .i_c   (r_carry),
        .o_sum (w_s_sum),
        .o_p   (w_s_p),
        .o_g   (w_s_g)
    );

    // Group P/G accumulate across nibbles exactly like a CLA level above the slice.
    assign w_carry_nx = w_s_g | (w_s_p & r_carry);
    assign w_g_nx     = w_s_g | (w_s_p & r_g_acc);
    assign w_p_nx     = r_p_acc & w_s_p;
    assign w_last     = (r_cnt == LAST_NIB);

    // Controller FSM: accept, per-nibble sequencing, and result hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_p_acc     <= 1'b0;
            r_g_acc     <= 1'b0;
            r_cout      <= 1'b0;
            r_p_all     <= 1'b0;
            r_g_all     <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
            r_sub       <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_init_carry;
                        r_p_acc <= 1'b1;
                        r_g_acc <= 1'b0;
                        r_cnt   <= '0;
`ifdef CLA_SEQ_SUB_EN
                        r_sub   <= sub;
`endif
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_cnt, 2'b00} +: 4] <= w_s_sum;
                    r_carry <= w_carry_nx;
                    r_g_acc <= w_g_nx;
                    r_p_acc <= w_p_nx;
                    if (w_last) begin
                        r_cout      <= w_carry_nx;
                        r_g_all     <= w_g_nx;
                        r_p_all     <= w_p_nx;
`ifdef CLA_SEQ_SUB_EN
                        // Carry into the MSB is recovered from the MSB sum bit and its operands.
                        r_ovf       <= (w_s_sum[3] ^ w_a_nib[3] ^ w_b_slice[3]) ^ w_carry_nx;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign p_all     = r_p_all;
    assign g_all     = r_g_all;
`ifdef CLA_SEQ_SUB_EN
    assign ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_cla_seq_nibble_adder.sv
// Scoreboard bench for cla_seq_nibble_adder: directed cases plus random ops against an arithmetic model.
// Subtract/overflow checks are compiled in when CLA_SEQ_SUB_EN is defined.

module tb_cla_seq_nibble_adder;
    localparam int WIDTH = 16;
    localparam int NIB   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             p_all;
    logic             g_all;
`ifdef CLA_SEQ_SUB_EN
    logic             sub;
    logic             ovf;
`endif

    cla_seq_nibble_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .p_all     (p_all),
        .g_all     (g_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        p;
        logic        g;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_ov = 1'b0;
    bit   rnd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, subtract as a + ~b + 1.
    function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                   input logic ci, input logic si);
        exp_t        m;
        logic [15:0] bb;
        logic        c0;
        logic [16:0] full;
        logic [16:0] gfull;
        bb     = si ? ~bi : bi;
        c0     = si ? 1'b1 : ci;
        full   = {1'b0, ai} + {1'b0, bb} + {16'd0, c0};
        gfull  = {1'b0, ai} + {1'b0, bb};
        m.sum  = full[15:0];
        m.cout = full[16];
        m.p    = ((ai ^ bb) == 16'hFFFF);
        m.g    = gfull[16];
        m.ovf  = (ai[15] == bb[15]) && (full[15] != ai[15]);
        m.acc  = 0;
        return m;
    endfunction

    task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        input logic si, output int acc);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        acc = -1;
        a = ai; b = bi; cin = ci;
`ifdef CLA_SEQ_SUB_EN
        sub = si;
`endif
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 2) != 0);
        end
        if (ok) begin
            e     = model(ai, bi, ci, si);
            e.acc = cyc + 1;
            acc   = e.acc;
            q.push_back(e);
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%0b", in_ready);
        end
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        chk("drain_queue", q.size(), 32'd0);
    endtask

    // Monitor: latency on out_valid rise, result compare on each output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_valid sum=%0h", sum);
                end else begin
                    chk("latency", cyc - q[0].acc, NIB);
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("sum",   {16'd0, sum},   {16'd0, e.sum});
                chk("cout",  {31'd0, cout},  {31'd0, e.cout});
                chk("p_all", {31'd0, p_all}, {31'd0, e.p});
                chk("g_all", {31'd0, g_all}, {31'd0, e.g});
`ifdef CLA_SEQ_SUB_EN
                chk("ovf",   {31'd0, ovf},   {31'd0, e.ovf});
`endif
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        int acc;
        int r;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'd0; b = 16'd0; cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {28'd0, cout, p_all, g_all, out_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(16'h1234, 16'h4321, 1'b0, 1'b0, acc); drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, acc); drain();
        send(16'h8000, 16'h8000, 1'b0, 1'b0, acc); drain();

        // Backpressure: result held, second request refused until consumer takes it.
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, acc);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        chk("bp_valid_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum_hold", {16'd0, sum}, 32'h5555);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        r = cyc;
        out_ready = 1'b1;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
        chk("bp_accept_delay", acc - r, 32'd2);
        drain();

        // Reset two cycles into a run abandons the op.
        send(16'hAAAA, 16'h5555, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_flags", {28'd0, cout, p_all, g_all, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(16'h0001, 16'h0001, 1'b0, 1'b0, acc); drain();

`ifdef CLA_SEQ_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, acc); drain();
        send(16'h8000, 16'h0001, 1'b1, 1'b1, acc); drain();
`endif

        rnd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom),
`ifdef CLA_SEQ_SUB_EN
                 1'($urandom),
`else
                 1'b0,
`endif
                 acc);
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
